// File: rtl/reg_file_wb.sv
// 32-entry register file for the 5-stage CPU: R0 hardwired to zero, one WB write port, two ID read ports, one debug port.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle WB write onto the ID read ports.
module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WBRegWrite,
    input  logic [ADDR_W-1:0] WBWriteReg,
    input  logic [DATA_W-1:0] WBwriteData,
    input  logic [ADDR_W-1:0] IDReadReg1,
    input  logic [ADDR_W-1:0] IDReadReg2,
    output logic [DATA_W-1:0] IDReadData1,
    output logic [DATA_W-1:0] IDReadData2,
    input  logic [ADDR_W-1:0] DbgReadReg,
    output logic [DATA_W-1:0] DbgReadData,
    output logic [31:0]       WriteCount
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [31:0]       writeCount;
    logic              commit;

    // Writes to R0 are dropped entirely so they neither store nor count.
    assign commit = WBRegWrite && (WBWriteReg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            writeCount <= '0;
        end else if (commit) begin
            regs[WBWriteReg] <= WBwriteData;
            writeCount       <= writeCount + 32'd1;
        end
    end

    always_comb begin
        IDReadData1 = regs[IDReadReg1];
`ifdef REGFILE_BYPASS_EN
        if (commit && (IDReadReg1 == WBWriteReg)) begin
            IDReadData1 = WBwriteData;
        end
`endif
        if (!rst_n || (IDReadReg1 == '0)) begin
            IDReadData1 = '0;
        end
    end

    always_comb begin
        IDReadData2 = regs[IDReadReg2];
`ifdef REGFILE_BYPASS_EN
        if (commit && (IDReadReg2 == WBWriteReg)) begin
            IDReadData2 = WBwriteData;
        end
`endif
        if (!rst_n || (IDReadReg2 == '0)) begin
            IDReadData2 = '0;
        end
    end

    // The debug port deliberately ignores the bypass and shows committed state only.
    always_comb begin
        DbgReadData = regs[DbgReadReg];
        if (!rst_n || (DbgReadReg == '0)) begin
            DbgReadData = '0;
        end
    end

    assign WriteCount = writeCount;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb; expected read values are queued as stimulus is driven, then popped and compared.
// Works for both builds; the collision expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_wb;

    logic        clk;
    logic        rst_n;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic [4:0]  idReadReg1;
    logic [4:0]  idReadReg2;
    logic [31:0] idReadData1;
    logic [31:0] idReadData2;
    logic [4:0]  dbgReadReg;
    logic [31:0] dbgReadData;
    logic [31:0] writeCount;

    int vectorsApplied = 0;
    int miscompares    = 0;

    logic [31:0] modelRegs [32];
    logic [31:0] modelCount;

    logic [31:0] expQ [$];
    int          selQ [$];
    string       tagQ [$];

    reg_file_wb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .WBRegWrite  (wbRegWrite),
        .WBWriteReg  (wbWriteReg),
        .WBwriteData (wbWriteData),
        .IDReadReg1  (idReadReg1),
        .IDReadReg2  (idReadReg2),
        .IDReadData1 (idReadData1),
        .IDReadData2 (idReadData2),
        .DbgReadReg  (dbgReadReg),
        .DbgReadData (dbgReadData),
        .WriteCount  (writeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input int sel, input string tag, input logic [31:0] expected);
        selQ.push_back(sel);
        tagQ.push_back(tag);
        expQ.push_back(expected);
    endtask

    task automatic drainScoreboard();
        logic [31:0] e;
        logic [31:0] obs;
        int          sel;
        string       tag;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            sel = selQ.pop_front();
            tag = tagQ.pop_front();
            case (sel)
                0:       obs = idReadData1;
                1:       obs = idReadData2;
                2:       obs = dbgReadData;
                default: obs = writeCount;
            endcase
            checkOutput(tag, obs, e);
        end
    endtask

    // Reference read value for an ID port given what is currently being driven.
    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (!rst_n || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wbRegWrite && wbWriteReg == idx) return wbWriteData;
`endif
        return modelRegs[idx];
    endfunction

    task automatic expectPorts(input string tag);
        pushExp(0, {tag, ".rs"},  expRead(idReadReg1));
        pushExp(1, {tag, ".rt"},  expRead(idReadReg2));
        pushExp(2, {tag, ".dbg"}, rst_n ? modelRegs[dbgReadReg] : 32'd0);
        pushExp(3, {tag, ".cnt"}, modelCount);
        drainScoreboard();
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        wbRegWrite  = we;
        wbWriteReg  = wreg;
        wbWriteData = wdata;
        idReadReg1  = r1;
        idReadReg2  = r2;
        dbgReadReg  = dbg;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && wbRegWrite && wbWriteReg != 5'd0) begin
            modelRegs[wbWriteReg] = wbWriteData;
            modelCount            = modelCount + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
        modelCount = 32'd0;
    endtask

    initial begin
        clearModel();
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd17);
        expectPorts("reset");
        rst_n = 1'b1;

        $display("[TB] basic write then read");
        applyStimulus(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        pushExp(0, "basic.rs",  32'h12345678);
        pushExp(1, "basic.rt",  32'h12345678);
        pushExp(3, "basic.cnt", 32'd1);
        drainScoreboard();

        $display("[TB] zero register");
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        pushExp(0, "zero.pre.rs", 32'd0);
        pushExp(2, "zero.pre.dbg", 32'd0);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        pushExp(0, "zero.rs",  32'd0);
        pushExp(2, "zero.dbg", 32'd0);
        pushExp(3, "zero.cnt", 32'd1);
        drainScoreboard();

        $display("[TB] collision");
        applyStimulus(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
        pushExp(1, "coll.same.rt", 32'h22);
        pushExp(0, "coll.same.rs", 32'h22);
`else
        pushExp(1, "coll.same.rt", 32'h11);
        pushExp(0, "coll.same.rs", 32'h11);
`endif
        pushExp(2, "coll.same.dbg", 32'h11);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
        pushExp(1, "coll.after.rt",  32'h22);
        pushExp(2, "coll.after.dbg", 32'h22);
        pushExp(3, "coll.after.cnt", 32'd3);
        drainScoreboard();

        $display("[TB] disabled write");
        applyStimulus(1'b1, 5'd9, 32'h5555, 5'd0, 5'd0, 5'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 5'd9, 32'hABCD, 5'd9, 5'd9, 5'd9);
            tick();
            pushExp(2, $sformatf("disabled%0d.dbg", c), 32'h5555);
            pushExp(0, $sformatf("disabled%0d.rs", c), 32'h5555);
            pushExp(3, $sformatf("disabled%0d.cnt", c), 32'd4);
            drainScoreboard();
        end

        $display("[TB] mid-run reset");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
        pushExp(2, "prereset.dbg", 32'hDEADBEEF);
        drainScoreboard();
        #2;
        rst_n = 1'b0;
        clearModel();
        #1;
        expectPorts("inreset");
        applyStimulus(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd7, 5'd5);
        expectPorts("inreset.write");
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 5'd5);
        pushExp(0, "released.rs",  32'd0);
        pushExp(1, "released.rt",  32'd0);
        pushExp(2, "released.dbg", 32'd0);
        pushExp(3, "released.cnt", 32'd0);
        drainScoreboard();

        $display("[TB] full sweep");
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0, 5'd0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i));
            pushExp(2, $sformatf("sweep.dbg%0d", i), 32'(i) * 32'h01010101);
            pushExp(0, $sformatf("sweep.rs%0d", i),  32'(i) * 32'h01010101);
            drainScoreboard();
        end
        pushExp(3, "sweep.cnt", 32'd31);
        drainScoreboard();

        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (n % 4 == 0) idReadReg1 = wbWriteReg;
            #1;
            expectPorts($sformatf("rand%0d", n));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
